// File: rtl/mxv_frame_decoder.sv
// mxv_frame_decoder
//
// Byte-level command frame decoder for the matrix-vector datapath.
// Accepts bytes from the serial receiver, checks a
//   HEADER, L, CMD, L payload bytes, TAIL
// frame and streams the payload bytes downstream. The payload byte count is
// tracked by an external command-length counter. This block drives that
// counter's enable, synchronous clear and length inputs, and reads back its
// finish flag to find the last payload byte.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-low reset
//   rx_data          received byte, qualified by rx_valid
//   rx_valid         one-cycle strobe per received byte
//   rx_parity_err    byte is corrupt; aborts any frame in progress
//   count_finish     counter flag, high when count == count_length-1
//   count_enable     counter enable (combinational)
//   count_sync_reset counter synchronous clear (combinational)
//   count_length     latched payload length L
//   cmd_code         latched command byte
//   payload_data     registered payload byte
//   payload_valid    one-cycle pulse per payload byte
//   payload_last     marks payload byte L-1
//   frame_done       one-cycle pulse after a correct tail byte
//   frame_error      one-cycle pulse on any abort
//   busy             high while a frame is in progress
module mxv_frame_decoder #(
  parameter int                     WORD_LENGTH = 8,
  parameter logic [WORD_LENGTH-1:0] HEADER      = 8'hFE,
  parameter logic [WORD_LENGTH-1:0] TAIL        = 8'hEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_parity_err,
  input  logic                   count_finish,
  output logic                   count_enable,
  output logic                   count_sync_reset,
  output logic [WORD_LENGTH-1:0] count_length,
  output logic [WORD_LENGTH-1:0] cmd_code,
  output logic [WORD_LENGTH-1:0] payload_data,
  output logic                   payload_valid,
  output logic                   payload_last,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    CMD     = 3'd2,
    PAYLOAD = 3'd3,
    TAILCHK = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic   byte_ok;
  logic   header_start;
  logic   payload_vld_p0;
  logic   payload_last_p0;
  logic   done_p0;
  logic   error_p0;
  logic   len_load_p0;
  logic   cmd_load_p0;

  // A byte is usable only when strobed and parity-clean.
  assign byte_ok      = rx_valid & ~rx_parity_err;
  assign header_start = byte_ok & (state_q == IDLE) & (rx_data == HEADER);

  // Clearing on every frame start re-aligns the counter even after an
  // aborted frame left it mid-count.
  assign count_sync_reset = header_start;
  assign count_enable     = header_start | (byte_ok & (state_q == PAYLOAD));

  assign busy = (state_q != IDLE);

  // Stage p0: decode the incoming byte against the current state.
  always_comb begin
    state_d         = state_q;
    payload_vld_p0  = 1'b0;
    payload_last_p0 = 1'b0;
    done_p0         = 1'b0;
    error_p0        = 1'b0;
    len_load_p0     = 1'b0;
    cmd_load_p0     = 1'b0;

    if (rx_valid) begin
      if (state_q != IDLE && rx_parity_err) begin
        error_p0 = 1'b1;
        state_d  = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Parity-flagged and non-header bytes are silently dropped.
            if (!rx_parity_err && rx_data == HEADER) begin
              state_d = LEN;
            end
          end
          LEN: begin
            if (rx_data == '0) begin
              error_p0 = 1'b1;
              state_d  = IDLE;
            end else begin
              len_load_p0 = 1'b1;
              state_d     = CMD;
            end
          end
          CMD: begin
            cmd_load_p0 = 1'b1;
            state_d     = PAYLOAD;
          end
          PAYLOAD: begin
            // HEADER/TAIL values are plain data here; only the counter
            // decides where the payload ends.
            payload_vld_p0  = 1'b1;
            payload_last_p0 = count_finish;
            if (count_finish) begin
              state_d = TAILCHK;
            end
          end
          TAILCHK: begin
            if (rx_data == TAIL) begin
              done_p0 = 1'b1;
            end else begin
              error_p0 = 1'b1;
            end
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // Stage p1: registered state and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_length  <= '0;
      cmd_code      <= '0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state_q       <= state_d;
      payload_valid <= payload_vld_p0;
      payload_last  <= payload_last_p0;
      frame_done    <= done_p0;
      frame_error   <= error_p0;
      if (len_load_p0) begin
        count_length <= rx_data;
      end
      if (cmd_load_p0) begin
        cmd_code <= rx_data;
      end
      if (payload_vld_p0) begin
        payload_data <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_mxv_frame_decoder.sv
// Testbench for mxv_frame_decoder: directed frames plus randomized frame
// streams, checked through an event scoreboard against a frame-level model.
// Also models the companion command-length counter.
module tb_mxv_frame_decoder;

  localparam logic [7:0] HDR = 8'hFE;
  localparam logic [7:0] TL  = 8'hEF;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       count_finish;
  logic       count_enable;
  logic       count_sync_reset;
  logic [7:0] count_length;
  logic [7:0] cmd_code;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic       payload_last;
  logic       frame_done;
  logic       frame_error;
  logic       busy;

  always #5 clk = ~clk;

  mxv_frame_decoder #(.WORD_LENGTH(8), .HEADER(HDR), .TAIL(TL)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_parity_err    (rx_parity_err),
    .count_finish     (count_finish),
    .count_enable     (count_enable),
    .count_sync_reset (count_sync_reset),
    .count_length     (count_length),
    .cmd_code         (cmd_code),
    .payload_data     (payload_data),
    .payload_valid    (payload_valid),
    .payload_last     (payload_last),
    .frame_done       (frame_done),
    .frame_error      (frame_error),
    .busy             (busy)
  );

  // Companion command-length counter.
  logic [7:0] cnt;
  assign count_finish = (cnt == 8'(count_length - 8'd1));
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 8'd0;
    else if (count_enable) cnt <= (count_sync_reset || count_finish) ? 8'd0 : cnt + 8'd1;
  end

  typedef struct packed {
    logic       pv;
    logic       pl;
    logic       done;
    logic       err;
    logic [7:0] data;
    logic [7:0] cmd;
    logic [7:0] len;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_ev;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       exp_busy = 1'b0;
  logic       exp_en   = 1'b0;
  logic       exp_sr   = 1'b0;
  logic [7:0] pbuf [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected event per output event.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      if (payload_valid || frame_done || frame_error) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got pv=%0b done=%0b err=%0b expected no event at %0t",
                   payload_valid, frame_done, frame_error, $time);
        end else begin
          mon_ev = sb.pop_front();
          check("event_kind", 32'({payload_valid, payload_last, frame_done, frame_error}),
                32'({mon_ev.pv, mon_ev.pl, mon_ev.done, mon_ev.err}));
          if (mon_ev.pv) check("payload_data", 32'(payload_data), 32'(mon_ev.data));
          if (mon_ev.done) begin
            check("cmd_code", 32'(cmd_code), 32'(mon_ev.cmd));
            check("count_length", 32'(count_length), 32'(mon_ev.len));
            check("counter_end", 32'(cnt), 32'd0);
          end
        end
      end
      check("busy", 32'(busy), 32'(exp_busy));
    end
  end

  // Counter drive is combinational: check it mid-cycle against the driver's intent.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      check("count_enable", 32'(count_enable), 32'(exp_en));
      check("count_sync_reset", 32'(count_sync_reset), 32'(exp_sr));
    end
  end

  task automatic drive(input logic [7:0] b, input logic par, input logic en,
                       input logic sr, input logic busy_after);
    @(negedge clk);
    rx_data       = b;
    rx_valid      = 1'b1;
    rx_parity_err = par;
    exp_en        = en;
    exp_sr        = sr;
    exp_busy      = busy_after;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid      = 1'b0;
      rx_parity_err = 1'($urandom);
      rx_data       = 8'($urandom);
      exp_en        = 1'b0;
      exp_sr        = 1'b0;
    end
  endtask

  // Frame-level reference: the outcome of each byte follows from its position
  // in the frame being sent. par_at >= 1 flags parity on that byte index;
  // stop_after >= 0 truncates the frame after that many bytes.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] cmd, input logic [7:0] tail,
                            input int par_at, input int stop_after, input int max_gap);
    int         total;
    int         n;
    logic [7:0] b;
    logic       par;
    logic       en;
    logic       fin;
    ev_t        e;
    n     = int'(len);
    total = (n == 0) ? 2 : n + 4;
    for (int j = 0; j < total; j++) begin
      if (stop_after >= 0 && j >= stop_after) break;
      if (j == 0) b = HDR;
      else if (j == 1) b = len;
      else if (j == 2) b = cmd;
      else if (j < 3 + n) b = pbuf[j-3];
      else b = tail;
      par = (j == par_at);
      en  = (j == 0) || (!par && j >= 3 && j < 3 + n);
      e   = '0;
      fin = 1'b0;
      if (par) begin
        e.err = 1'b1;
        fin   = 1'b1;
      end else if (n == 0 && j == 1) begin
        e.err = 1'b1;
        fin   = 1'b1;
      end else if (j >= 3 && j < 3 + n) begin
        e.pv   = 1'b1;
        e.pl   = (j == 2 + n);
        e.data = b;
      end else if (j == 3 + n) begin
        if (tail == TL) e.done = 1'b1;
        else e.err = 1'b1;
        e.cmd = cmd;
        e.len = len;
        fin   = 1'b1;
      end
      drive(b, par, en, (j == 0), !fin);
      if (e.pv || e.done || e.err) sb.push_back(e);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      if (fin) break;
    end
  endtask

  task automatic send_garbage(input logic [7:0] b, input logic par);
    drive(b, par, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle(2);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    exp_en   = 1'b0;
    exp_sr   = 1'b0;
    exp_busy = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_payload_valid", 32'(payload_valid), 32'd0);
    check("rst_payload_last", 32'(payload_last), 32'd0);
    check("rst_payload_data", 32'(payload_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_cmd_code", 32'(cmd_code), 32'd0);
    check("rst_count_length", 32'(count_length), 32'd0);
    check("rst_counter", 32'(cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         L;
    int         kind;
    int         par_at;
    logic [7:0] cmd;
    logic [7:0] tail;
    logic [7:0] g;

    reset         = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    rx_parity_err = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Nominal frame, back-to-back strobes.
    pbuf[0] = 8'h10; pbuf[1] = 8'h20; pbuf[2] = 8'h30;
    send_frame(8'd3, 8'hA1, TL, -1, -1, 0);
    drain();

    // L=1 with idle gaps.
    pbuf[0] = 8'h7E;
    send_frame(8'd1, 8'h05, TL, -1, -1, 3);
    drain();

    // Bad tail, then a good frame immediately after.
    pbuf[0] = 8'h11; pbuf[1] = 8'h22;
    send_frame(8'd2, 8'hB0, 8'hAA, -1, -1, 0);
    pbuf[0] = 8'h33;
    send_frame(8'd1, 8'hC0, TL, -1, -1, 0);
    drain();

    // Zero length, then garbage (including parity-flagged HEADER) in IDLE.
    send_frame(8'd0, 8'h00, TL, -1, -1, 0);
    send_garbage(8'h55, 1'b0);
    send_garbage(8'h12, 1'b0);
    send_garbage(HDR, 1'b1);
    drain();

    // Payload containing HEADER/TAIL values.
    pbuf[0] = HDR; pbuf[1] = TL;
    send_frame(8'd2, 8'hC3, TL, -1, -1, 0);
    drain();

    // Parity error on the 2nd payload byte.
    pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03;
    send_frame(8'd3, 8'hD0, TL, 4, -1, 0);
    drain();

    // Reset mid-payload, then a normal frame.
    pbuf[0] = 8'h41; pbuf[1] = 8'h42; pbuf[2] = 8'h43; pbuf[3] = 8'h44;
    send_frame(8'd4, 8'hE1, TL, -1, 5, 0);
    drain();
    do_reset();
    pbuf[0] = 8'h9A; pbuf[1] = 8'hBC;
    send_frame(8'd2, 8'h5D, TL, -1, -1, 0);
    drain();

    // Maximum length frame.
    for (int i = 0; i < 255; i++) pbuf[i] = 8'($urandom);
    send_frame(8'd255, 8'h77, TL, -1, -1, 0);
    drain();

    // Randomized frame stream.
    for (int f = 0; f < 40; f++) begin
      kind   = $urandom_range(0, 5);
      L      = $urandom_range(1, 12);
      cmd    = 8'($urandom);
      tail   = TL;
      par_at = -1;
      for (int i = 0; i < L; i++) begin
        case ($urandom_range(0, 5))
          0:       pbuf[i] = HDR;
          1:       pbuf[i] = TL;
          default: pbuf[i] = 8'($urandom);
        endcase
      end
      case (kind)
        2: begin
          tail = 8'($urandom);
          if (tail == TL) tail = 8'h00;
        end
        3: L = 0;
        4: par_at = $urandom_range(1, L + 3);
        default: ;
      endcase
      send_frame(8'(L), cmd, tail, par_at, -1, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom);
        if (g == HDR) g = 8'h00;
        send_garbage(g, 1'($urandom));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
